// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry, well-known scan codes and the
// frame integrity check used by the receiver.
package ps2_pkg;

   localparam int PS2_FRAME_BITS = 11;

   typedef logic [7:0] scan_code_t;

   localparam scan_code_t SC_BREAK = 8'hF0;
   localparam scan_code_t SC_EXT   = 8'hE0;

   // bits[0] = start, bits[8:1] = data (LSB first), bits[9] = parity.
   // A frame is good when start is low, stop is high and parity is odd.
   function automatic logic frame_ok(input logic [9:0] bits, input logic stop);
      return (bits[0] == 1'b0) && (stop == 1'b1) && ((^bits[9:1]) == 1'b1);
   endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Small synchronous FIFO for received scan codes. Pointers carry an extra
// wrap bit so full and empty can be told apart without a counter.
module ps2_sync_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       empty,
   output logic       full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   assign do_pop  = pop & ~empty;
   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? 8'h00 : mem[rptr[AW-1:0]];

   // Storage write; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr[AW-1:0]] <= wdata;
      end
   end

   // Read/write pointer advance, wrapping modulo 2*DEPTH.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + PTR_ONE;
         end
         if (do_pop) begin
            rptr <= rptr + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the raw lines, deframes 11-bit frames,
// validates start/stop/parity and buffers good scan codes for the consumer.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [3:0]    LAST_BIT    = 4'(PS2_FRAME_BITS - 1);
   localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMO_ONE     = TW'(1);

   logic [2:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          fall;
   logic [3:0]    bit_cnt;
   logic [9:0]    shift;
   logic [TW-1:0] tmo_cnt;
   logic          frame_done;
   logic          frame_valid;
   logic          push_req;
   logic          pop;
   logic          empty;
   logic          full;
   logic [7:0]    rdata;

   // clk_sync[0] is the newest sample, clk_sync[2] the oldest: a falling
   // edge is the older sample high while the newer one is already low.
   assign fall        = clk_sync[2] & ~clk_sync[1];
   assign frame_done  = fall & (bit_cnt == LAST_BIT);
   assign frame_valid = frame_ok(shift, data_sync[1]);
   assign push_req    = frame_done & frame_valid;
   assign pop         = ~nextdata_n & ~empty;
   assign ready       = ~empty;
   assign data        = rdata;

   // Synchronise the asynchronous PS/2 lines; idle level is high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_sync  <= 3'b111;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // Bit counter, shift register and inactivity timeout for the current frame.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bit_cnt <= 4'd0;
         shift   <= 10'd0;
         tmo_cnt <= '0;
      end else if (fall) begin
         tmo_cnt <= '0;
         if (bit_cnt == LAST_BIT) begin
            bit_cnt <= 4'd0;
         end else begin
            bit_cnt <= bit_cnt + 4'd1;
            shift   <= {data_sync[1], shift[9:1]};
         end
      end else if (bit_cnt != 4'd0) begin
         if (tmo_cnt == TIMEOUT_VAL) begin
            bit_cnt <= 4'd0;
            shift   <= 10'd0;
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
         end
      end else begin
         tmo_cnt <= '0;
      end
   end

   // Error pulse for a bad frame and sticky flag for a byte lost to a full FIFO.
   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         frame_err <= frame_done & ~frame_valid;
         if (push_req & full & ~pop) begin
            overflow <= 1'b1;
         end
      end
   end

   ps2_sync_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop),
      .wdata (shift[8:1]),
      .rdata (rdata),
      .empty (empty),
      .full  (full)
   );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed scenarios plus randomized
// frames, compared against a queue-based model of the receiver's behaviour.
module tb_ps2_rx_fifo;

   localparam int DEPTH   = 8;
   localparam int TMO     = 200;
   localparam int HALF    = 8;
   localparam int K_GOOD  = 0;
   localparam int K_PAR   = 1;
   localparam int K_START = 2;
   localparam int K_STOP  = 3;

   logic       clk        = 1'b0;
   logic       rst        = 1'b0;
   logic       ps2_clk    = 1'b1;
   logic       ps2_data   = 1'b1;
   logic       nextdata_n = 1'b1;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   int checks     = 0;
   int errors     = 0;
   int err_cycles = 0;

   logic [7:0] q[$];
   logic       ovf_m = 1'b0;

   ps2_rx_fifo #(
      .DEPTH       (DEPTH),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdata_n (nextdata_n),
      .data       (data),
      .ready      (ready),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   // Count every cycle frame_err is seen high.
   always @(negedge clk) begin
      if (frame_err === 1'b1) err_cycles++;
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_data();
      return (q.size() > 0) ? q[0] : 8'h00;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_ready"}, 32'(ready), 32'(q.size() > 0));
      check({tag, "_data"}, 32'(data), 32'(exp_data()));
      check({tag, "_ovf"}, 32'(overflow), 32'(ovf_m));
   endtask

   // Frame bit i goes on the wire i-th: start, data LSB first, parity, stop.
   function automatic logic [10:0] make_frame(input logic [7:0] b, input int kind);
      logic st;
      logic par;
      logic sp;
      st  = 1'b0;
      par = ~(^b);
      sp  = 1'b1;
      if (kind == K_PAR)   par = ~par;
      if (kind == K_START) st  = 1'b1;
      if (kind == K_STOP)  sp  = 1'b0;
      return {sp, par, b, st};
   endfunction

   // Drive nbits of a frame; with a full frame, check the result 4 cycles
   // after the last falling edge. pop_push pops exactly on the push cycle.
   task automatic send(input logic [7:0] b, input int kind, input int nbits, input bit pop_push);
      logic [10:0] fr;
      int lat;
      int err0;
      bit was_empty;
      fr   = make_frame(b, kind);
      err0 = err_cycles;
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == 10) begin
            lat       = 0;
            was_empty = (q.size() == 0);
            for (int c = 1; c <= 4; c++) begin
               @(negedge clk);
               if (ready === 1'b1 && lat == 0) lat = c;
               if (pop_push && c == 2) nextdata_n = 1'b0;
               if (c == 3) nextdata_n = 1'b1;
            end
            if (pop_push && q.size() > 0) void'(q.pop_front());
            if (kind == K_GOOD) begin
               if (q.size() < DEPTH) q.push_back(b);
               else ovf_m = 1'b1;
            end
            if (kind == K_GOOD && was_empty && !pop_push)
               check("latency", 32'(lat >= 1 && lat <= 4), 32'd1);
            check_outputs("frame");
            repeat (HALF - 4) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         ps2_clk = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      ps2_data = 1'b1;
      check("frame_err_cycles", 32'(err_cycles - err0),
            32'((nbits == 11 && kind != K_GOOD) ? 1 : 0));
   endtask

   task automatic pop_one(input string tag);
      @(negedge clk);
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
      if (q.size() > 0) void'(q.pop_front());
      check_outputs(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      ovf_m = 1'b0;
      check_outputs("reset");
      check("reset_ferr", 32'(frame_err), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      check_outputs("por");
      check("por_ferr", 32'(frame_err), 32'd0);

      // single frame, then pop it
      send(8'h1C, K_GOOD, 11, 1'b0);
      pop_one("pop_single");

      // three frames in order, then drain plus an ignored pop on empty
      send(8'h1C, K_GOOD, 11, 1'b0);
      send(8'hF0, K_GOOD, 11, 1'b0);
      send(8'h1C, K_GOOD, 11, 1'b0);
      for (int i = 0; i < 4; i++) pop_one("pop_seq");

      // corrupted frames
      send(8'h15, K_PAR, 11, 1'b0);
      send(8'h15, K_STOP, 11, 1'b0);
      send(8'h15, K_START, 11, 1'b0);

      // overflow on the ninth frame, then drain
      for (int i = 1; i <= 9; i++) send(8'(i), K_GOOD, 11, 1'b0);
      for (int i = 0; i < 8; i++) pop_one("pop_ovf");

      // full FIFO with a pop on the push cycle keeps the new byte
      do_reset();
      for (int i = 1; i <= 8; i++) send(8'(8'h10 + i), K_GOOD, 11, 1'b0);
      send(8'h19, K_GOOD, 11, 1'b1);
      for (int i = 0; i < 8; i++) pop_one("pop_full");

      // stray edges abandoned by the timeout
      send(8'hAA, K_GOOD, 5, 1'b0);
      repeat (TMO + 2) @(negedge clk);
      send(8'h15, K_GOOD, 11, 1'b0);
      pop_one("pop_tmo");

      // reset in the middle of a frame
      send(8'h55, K_GOOD, 6, 1'b0);
      do_reset();
      send(8'h24, K_GOOD, 11, 1'b0);
      pop_one("pop_rst");

      // randomized traffic
      do_reset();
      for (int n = 0; n < 40; n++) begin
         int kind;
         kind = ($urandom_range(0, 9) < 7) ? K_GOOD : int'($urandom_range(1, 3));
         send(8'($urandom_range(0, 255)), kind, 11, ($urandom_range(0, 7) == 0));
         for (int p = 0; p < int'($urandom_range(0, 2)); p++) pop_one("pop_rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
